// File: rtl/cache_ctrl.sv
// Request sequencer in front of the single-port cache store: load/store handshake, cache lookup,
// memory fetch and fill on a miss, write-through/write-update stores, saturating hit/miss statistics.
module cache_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    output logic                  cache_oe,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_CHECK     = 3'd2,
        S_MEM_READ  = 3'd3,
        S_FILL      = 3'd4,
        S_MEM_WRITE = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 32'd1);

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_WIDTH-1:0] cache_wdata_q, cache_wdata_d;
    logic                  cache_we_q, cache_we_d;
    logic                  cache_oe_q, cache_oe_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [15:0]           hit_count_q, hit_count_d;
    logic [15:0]           miss_count_q, miss_count_d;
    logic                  tmo_expire;

    // A mem_ack in the limit cycle is tested first, so it wins over the timeout.
    assign tmo_expire = (tmo_q == TMO_LAST);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= {DATA_WIDTH{1'b0}};
            resp_err_q    <= 1'b0;
            cache_addr_q  <= {ADDR_WIDTH{1'b0}};
            cache_wdata_q <= {DATA_WIDTH{1'b0}};
            cache_we_q    <= 1'b0;
            cache_oe_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q   <= {DATA_WIDTH{1'b0}};
            tmo_q         <= 16'd0;
            hit_count_q   <= 16'd0;
            miss_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            cache_we_q    <= cache_we_d;
            cache_oe_q    <= cache_oe_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tmo_q         <= tmo_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = req_we ? S_MEM_WRITE : S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (cache_hit) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end else if (tmo_expire) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_FILL: state_d = S_RESP;
            S_MEM_WRITE: begin
                if (mem_ack || tmo_expire) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and timeout counter.
    always_comb begin
        // Strobes follow the state being entered so they are visible in that state's cycle.
        req_ready_d   = (state_d == S_IDLE);
        resp_valid_d  = (state_d == S_RESP);
        cache_oe_d    = (state_d == S_LOOKUP);
        mem_req_d     = (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE);
        mem_we_d      = (state_d == S_MEM_WRITE);
        cache_we_d    = (state_d == S_FILL) || ((state_q == S_IDLE) && (state_d == S_MEM_WRITE));
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        tmo_d         = tmo_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = 16'd0;
                if (req_valid && req_ready_q) begin
                    cache_addr_d  = req_addr;
                    cache_wdata_d = req_wdata;
                    mem_addr_d    = req_addr;
                    mem_wdata_d   = req_wdata;
                end else begin
                    cache_addr_d  = cache_addr_q;
                    cache_wdata_d = cache_wdata_q;
                end
            end
            S_CHECK: begin
                tmo_d = 16'd0;
                if (cache_hit) begin
                    resp_rdata_d = cache_rdata;
                    hit_count_d  = sat_inc(hit_count_q);
                end else begin
                    miss_count_d = sat_inc(miss_count_q);
                end
            end
            S_MEM_READ: begin
                if (mem_ack) begin
                    resp_rdata_d  = mem_rdata;
                    cache_wdata_d = mem_rdata;
                end else if (tmo_expire) begin
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
                    resp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ack) begin
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
                    resp_err_d   = 1'b0;
                end else if (tmo_expire) begin
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
                    resp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_err_d = 1'b0;
                end else begin
                    resp_err_d = resp_err_q;
                end
            end
            default: begin
                tmo_d = tmo_q;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wdata = cache_wdata_q;
    assign cache_we    = cache_we_q;
    assign cache_oe    = cache_oe_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a vector table of load/store transactions against a small cache and
// memory responder, plus hand-written backpressure, reset-abort and counter-saturation sequences.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;
    logic [9:0]  cache_addr;
    logic [15:0] cache_wdata, cache_rdata;
    logic        cache_we, cache_oe, cache_hit;
    logic        mem_req, mem_we, mem_ack;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    int n_vec = 0;
    int n_bad = 0;

    cache_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we), .cache_oe(cache_oe),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // ack = mem_req cycle (1-based) in which mem_ack is pulsed, 0 = never.
    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        hit;
        logic [15:0] crd;
        int          ack;
        logic [15:0] mrd;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_cwe;
        logic [15:0] exp_cwdata;
        int          exp_mem;
        logic [15:0] exp_hits;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with resp_ready=1, play cache and memory, and check the response.
    task automatic run_vec(input string tag, input vec_t v);
        int          cyc, memcyc, oe_n, cwe_n, lat, side_bad;
        logic        oe_prev, got, er;
        logic [15:0] rd, cw_data;
        logic [9:0]  cw_addr;
        cyc = 1; memcyc = 0; oe_n = 0; cwe_n = 0; lat = 0; side_bad = 0;
        oe_prev = 1'b0; got = 1'b0; er = 1'b0; rd = 16'h0; cw_data = 16'h0; cw_addr = 10'h0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        step();
        req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata;
        while (!got && cyc < 40) begin
            cache_hit   = oe_prev ? v.hit : ~v.hit;
            cache_rdata = oe_prev ? v.crd : ~v.crd;
            oe_prev     = cache_oe;
            if (cache_oe) begin
                oe_n++;
                if (cache_addr !== v.addr) side_bad++;
            end
            if (cache_we) begin
                cwe_n++;
                cw_addr = cache_addr;
                cw_data = cache_wdata;
            end
            if (mem_req) begin
                memcyc++;
                if (mem_we !== v.we || mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata)) side_bad++;
                mem_ack   = (v.ack != 0) && (memcyc == v.ack);
                mem_rdata = mem_ack ? v.mrd : ~v.mrd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'h0;
            end
            if (req_ready !== 1'b0) side_bad++;
            if (resp_valid) begin
                got = 1'b1; lat = cyc; rd = resp_rdata; er = resp_err;
            end else begin
                step();
                cyc++;
            end
        end
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
        chk({tag, "_err"}, 32'(er), 32'(v.exp_err));
        chk({tag, "_oe_pulses"}, 32'(oe_n), v.we ? 32'd0 : 32'd1);
        chk({tag, "_cache_we_pulses"}, 32'(cwe_n), 32'(v.exp_cwe));
        chk({tag, "_mem_req_cycles"}, 32'(memcyc), 32'(v.exp_mem));
        chk({tag, "_side_signals"}, 32'(side_bad), 32'd0);
        if (v.exp_cwe != 0) begin
            chk({tag, "_fill_addr"}, 32'(cw_addr), 32'(v.addr));
            chk({tag, "_fill_data"}, 32'(cw_data), 32'(v.exp_cwdata));
        end
        mem_ack = 1'b0;
        step();
        chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   waited;
        int   bad;
        vec_t hv, mv;
        //           we    addr    wdata    hit   crd      ack mrd      exp_rd   err  lat cwe cwdata   mem hits    miss
        vecs[0] = '{1'b0, 10'h005, 16'h0000, 1'b1, 16'hBEEF, 0, 16'h0000, 16'hBEEF, 1'b0, 3, 0, 16'h0000, 0, 16'd1, 16'd0};
        vecs[1] = '{1'b0, 10'h3FF, 16'h0000, 1'b0, 16'h4444, 5, 16'h1234, 16'h1234, 1'b0, 9, 1, 16'h1234, 5, 16'd1, 16'd1};
        vecs[2] = '{1'b1, 10'h010, 16'hA5A5, 1'b0, 16'h0000, 3, 16'h7777, 16'h0000, 1'b0, 4, 1, 16'hA5A5, 3, 16'd1, 16'd1};
        vecs[3] = '{1'b0, 10'h020, 16'h0000, 1'b0, 16'h2222, 0, 16'h0000, 16'h0000, 1'b1, 11, 0, 16'h0000, 8, 16'd1, 16'd2};
        vecs[4] = '{1'b0, 10'h021, 16'h0000, 1'b0, 16'h3333, 8, 16'h0F0F, 16'h0F0F, 1'b0, 12, 1, 16'h0F0F, 8, 16'd1, 16'd3};
        vecs[5] = '{1'b0, 10'h000, 16'h0000, 1'b1, 16'h7FFF, 0, 16'h0000, 16'h7FFF, 1'b0, 3, 0, 16'h0000, 0, 16'd2, 16'd3};
        vecs[6] = '{1'b1, 10'h3FF, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1, 9, 1, 16'hFFFF, 8, 16'd2, 16'd3};
        vecs[7] = '{1'b0, 10'h155, 16'h0000, 1'b0, 16'h1111, 1, 16'hCAFE, 16'hCAFE, 1'b0, 5, 1, 16'hCAFE, 1, 16'd2, 16'd4};
        vecs[8] = '{1'b1, 10'h2AA, 16'h5555, 1'b0, 16'h0000, 1, 16'h6666, 16'h0000, 1'b0, 2, 1, 16'h5555, 1, 16'd2, 16'd4};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'h0; req_wdata = 16'h0;
        resp_ready = 1'b1; cache_rdata = 16'h0; cache_hit = 1'b0; mem_rdata = 16'h0; mem_ack = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_strobes", {28'd0, cache_we, cache_oe, mem_req, mem_we}, 32'd0);
        chk("rst_addrs", {12'd0, cache_addr, mem_addr}, 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            chk($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].exp_hits));
            chk($sformatf("v%0d_miss_count", i), 32'(miss_count), 32'(vecs[i].exp_miss));
        end

        // Backpressure: response must hold while resp_ready is low, new requests ignored.
        resp_ready = 1'b0; cache_hit = 1'b1; cache_rdata = 16'h1357;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h0AB;
        step();
        req_valid = 1'b0;
        waited = 0;
        while (!resp_valid && waited < 10) begin
            step();
            waited++;
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1; req_addr = 10'h111; req_we = 1'b0;
            step();
            chk($sformatf("bp%0d_valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", c), 32'(resp_rdata), 32'h1357);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_busy", c), {30'd0, cache_oe, mem_req}, 32'd0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        step();
        chk("bp_no_capture", {30'd0, cache_oe, mem_req}, 32'd0);
        chk("bp_hit_count", 32'(hit_count), 32'd3);

        // Reset while waiting on memory aborts everything at that edge.
        cache_hit = 1'b0; cache_rdata = 16'h0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h0C3;
        step();
        req_valid = 1'b0;
        waited = 0;
        while (!mem_req && waited < 10) begin
            step();
            waited++;
        end
        chk("rmid_mem_req_seen", 32'(mem_req), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_mem_req", 32'(mem_req), 32'd0);
        chk("rmid_req_ready", 32'(req_ready), 32'd1);
        chk("rmid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rmid_counts", {hit_count, miss_count}, 32'd0);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (resp_valid || cache_we || mem_req || cache_oe || !req_ready) bad++;
        end
        chk("rmid_quiet_after", 32'(bad), 32'd0);

        // Saturation: counters preloaded near the top must stop at 16'hFFFF.
        force dut.hit_count_q = 16'hFFFE;
        force dut.miss_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_count_q;
        release dut.miss_count_q;
        step();
        hv = vecs[0];
        mv = vecs[7];
        run_vec("sat_h1", hv);
        chk("sat_h1_hits", 32'(hit_count), 32'hFFFF);
        run_vec("sat_h2", hv);
        chk("sat_h2_hits", 32'(hit_count), 32'hFFFF);
        run_vec("sat_m1", mv);
        chk("sat_m1_miss", 32'(miss_count), 32'hFFFF);
        chk("sat_m1_hits", 32'(hit_count), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
